// File: rtl/cmd_seq_ctrl_pkg.sv
// Shared types and constants for the SD command sequencer.
package cmd_seq_ctrl_pkg;

    localparam int unsigned CmdNrWidth = 6;
    localparam int unsigned ArgWidth   = 32;
    localparam int unsigned ErrWidth   = 4;

    // Bit positions inside the error pulse vector {index, end bit, crc, timeout}
    localparam int unsigned ErrTimeoutBit = 0;
    localparam int unsigned ErrCrcBit     = 1;
    localparam int unsigned ErrEndBit     = 2;
    localparam int unsigned ErrIdxBit     = 3;

    localparam logic [CmdNrWidth-1:0] CMD12 = 6'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_TX_WAIT,
        ST_RSP_WAIT,
        ST_FINISH
    } cmd_seq_state_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'b00,
        RSP_48   = 2'b01,
        RSP_136  = 2'b10
    } rsp_type_e;

    // Everything the sequencer needs to run one command
    typedef struct packed {
        logic [CmdNrWidth-1:0] nr;
        logic [ArgWidth-1:0]   arg;
        rsp_type_e             rsp_type;
        logic                  idx_chk;
    } cmd_desc_t;

    // Reserved encoding 2'b11 behaves like a 48-bit response
    function automatic rsp_type_e decode_rsp_type(input logic [1:0] raw);
        case (raw)
            2'b00:   return RSP_NONE;
            2'b10:   return RSP_136;
            default: return RSP_48;
        endcase
    endfunction

endpackage

// File: rtl/cmd_seq_ctrl_if.sv
// Sequencer <-> CMD transmitter / response receiver signals.
interface cmd_seq_ctrl_if;
    import cmd_seq_ctrl_pkg::*;

    logic                  start_tx;
    logic [CmdNrWidth-1:0] cmd_nr;
    logic [ArgWidth-1:0]   cmd_argument;
    logic                  tx_done;
    logic                  rsp_arm;
    logic                  rsp_long;
    logic                  rsp_started;
    logic                  rsp_done;
    logic                  rsp_crc_err;
    logic                  rsp_end_err;
    logic [CmdNrWidth-1:0] rsp_idx;

    modport master (
        output start_tx, cmd_nr, cmd_argument, rsp_arm, rsp_long,
        input  tx_done, rsp_started, rsp_done, rsp_crc_err, rsp_end_err, rsp_idx
    );

    modport slave (
        input  start_tx, cmd_nr, cmd_argument, rsp_arm, rsp_long,
        output tx_done, rsp_started, rsp_done, rsp_crc_err, rsp_end_err, rsp_idx
    );

endinterface

// File: rtl/cmd_seq_ctrl.sv
// SD CMD sequencer: arbitrates sw / auto-CMD12, drives transmitter, times out responses.
module cmd_seq_ctrl
    import cmd_seq_ctrl_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 64,
    parameter int unsigned CntWidth      = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clk_en_p_i,
    input  logic                  sw_req_i,
    input  logic [CmdNrWidth-1:0] sw_cmd_nr_i,
    input  logic [ArgWidth-1:0]   sw_arg_i,
    input  logic [1:0]            sw_rsp_type_i,
    input  logic                  sw_idx_chk_i,
    input  logic                  auto12_req_i,
    cmd_seq_ctrl_if.master        phy,
    output logic                  cmd_inhibit_o,
    output logic                  cmd_complete_o,
    output logic                  auto12_done_o,
    output logic [ErrWidth-1:0]   err_o
);

    cmd_seq_state_e        state_q, state_d;
    cmd_desc_t             cur_q, cur_d, sw_q, sw_d;
    logic                  src_auto_q, src_auto_d;
    logic                  pend_sw_q, pend_sw_d;
    logic                  pend_a12_q, pend_a12_d;
    logic                  started_q, started_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ErrWidth-1:0]   err_q, err_d;

    logic                  start_tx_q, start_tx_d;
    logic                  rsp_arm_q, rsp_arm_d;
    logic                  rsp_long_q, rsp_long_d;
    logic                  inhibit_q, inhibit_d;
    logic                  complete_q, complete_d;
    logic                  a12_done_q, a12_done_d;
    logic [ErrWidth-1:0]   err_out_q, err_out_d;

    logic                  sw_accept;
    logic                  started_any;
    logic [CntWidth-1:0]   cnt_inc;

    assign sw_accept   = sw_req_i & ~inhibit_q;
    assign started_any = started_q | phy.rsp_started;
    assign cnt_inc     = cnt_q + CntWidth'(1);

    // State, command context and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            sw_q       <= '0;
            src_auto_q <= 1'b0;
            pend_sw_q  <= 1'b0;
            pend_a12_q <= 1'b0;
            started_q  <= 1'b0;
            cnt_q      <= '0;
            err_q      <= '0;
            start_tx_q <= 1'b0;
            rsp_arm_q  <= 1'b0;
            rsp_long_q <= 1'b0;
            inhibit_q  <= 1'b0;
            complete_q <= 1'b0;
            a12_done_q <= 1'b0;
            err_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            sw_q       <= sw_d;
            src_auto_q <= src_auto_d;
            pend_sw_q  <= pend_sw_d;
            pend_a12_q <= pend_a12_d;
            started_q  <= started_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            start_tx_q <= start_tx_d;
            rsp_arm_q  <= rsp_arm_d;
            rsp_long_q <= rsp_long_d;
            inhibit_q  <= inhibit_d;
            complete_q <= complete_d;
            a12_done_q <= a12_done_d;
            err_out_q  <= err_out_d;
        end
    end

    // Next state, arbitration, timeout counting and error capture
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        src_auto_d = src_auto_q;
        started_d  = started_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        pend_sw_d  = pend_sw_q | sw_accept;
        pend_a12_d = pend_a12_q | auto12_req_i;
        sw_d       = sw_q;
        if (sw_accept) begin
            sw_d = '{nr: sw_cmd_nr_i, arg: sw_arg_i,
                     rsp_type: decode_rsp_type(sw_rsp_type_i), idx_chk: sw_idx_chk_i};
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_a12_q) begin
                    cur_d      = '{nr: CMD12, arg: '0, rsp_type: RSP_48, idx_chk: 1'b1};
                    src_auto_d = 1'b1;
                    pend_a12_d = auto12_req_i;
                    err_d      = '0;
                    state_d    = ST_ISSUE;
                end else if (pend_sw_q) begin
                    cur_d      = sw_q;
                    src_auto_d = 1'b0;
                    pend_sw_d  = sw_accept;
                    err_d      = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Transmitter has taken the start once it reports busy on an SD tick
                if (clk_en_p_i && !phy.tx_done) begin
                    state_d = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (clk_en_p_i && phy.tx_done) begin
                    if (cur_q.rsp_type == RSP_NONE) begin
                        state_d = ST_FINISH;
                    end else begin
                        cnt_d     = '0;
                        started_d = 1'b0;
                        state_d   = ST_RSP_WAIT;
                    end
                end
            end
            ST_RSP_WAIT: begin
                started_d = started_any;
                if (phy.rsp_done) begin
                    err_d[ErrCrcBit] = phy.rsp_crc_err;
                    err_d[ErrEndBit] = phy.rsp_end_err;
                    err_d[ErrIdxBit] = cur_q.idx_chk && (phy.rsp_idx != cur_q.nr);
                    state_d          = ST_FINISH;
                end else if (clk_en_p_i && !started_any) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntWidth'(TimeoutCycles)) begin
                        err_d[ErrTimeoutBit] = 1'b1;
                        state_d              = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state
    always_comb begin
        start_tx_d = (state_d == ST_ISSUE);
        rsp_arm_d  = (state_d == ST_RSP_WAIT);
        rsp_long_d = rsp_arm_d && (cur_d.rsp_type == RSP_136);
        complete_d = (state_d == ST_FINISH) && !src_auto_d;
        a12_done_d = (state_d == ST_FINISH) && src_auto_d;
        err_out_d  = (state_d == ST_FINISH) ? err_d : '0;
        inhibit_d  = (inhibit_q | sw_accept) & ~complete_d;
    end

    assign phy.start_tx     = start_tx_q;
    assign phy.cmd_nr       = cur_q.nr;
    assign phy.cmd_argument = cur_q.arg;
    assign phy.rsp_arm      = rsp_arm_q;
    assign phy.rsp_long     = rsp_long_q;
    assign cmd_inhibit_o    = inhibit_q;
    assign cmd_complete_o   = complete_q;
    assign auto12_done_o    = a12_done_q;
    assign err_o            = err_out_q;

endmodule
